// File: rtl/game_pkg.sv
// Shared game definitions: vertical-motion state encodings, screen geometry
// and the motion tick rate used by both the player and the platform scroller.
package game_pkg;

  typedef enum logic [1:0] {
    STAND = 2'd0,
    RISE  = 2'd1,
    FALL  = 2'd2,
    DEAD  = 2'd3
  } pstate_t;

  localparam logic [9:0] SCREEN_BOTTOM    = 10'd479;
  localparam int         TICK_DIV_DEFAULT = 840000;
  localparam int         TICK_W           = 20;

endpackage

// File: rtl/motion_tick.sv
// Free-running motion tick divider: tick pulses for one clk every DIV clocks.
// clear restarts the period so the next tick lands exactly DIV clocks later.
module motion_tick #(
  parameter int DIV = 840000,
  parameter int W   = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear || tick)
      count <= '0;
    else
      count <= count + 1'b1;
  end

endmodule

// File: rtl/player_vertical.sv
// Vertical motion of the climber: rides the platform while standing, runs a
// tick-stepped jump/gravity arc, and detects landing or falling off-screen.
//
// state | meaning
// STAND | feet glued to plataform_start every clk
// RISE  | moving up, speed decays by GRAVITY each tick
// FALL  | moving down, speed grows to MAX_FALL each tick
// DEAD  | fell off-screen; only rst leaves
module player_vertical
  import game_pkg::*;
#(
  parameter int         TICK_DIV = TICK_DIV_DEFAULT,
  parameter logic [5:0] JUMP_V   = 6'd12,
  parameter logic [5:0] GRAVITY  = 6'd1,
  parameter logic [5:0] MAX_FALL = 6'd12,
  parameter logic [9:0] PLAYER_H = 10'd40,
  parameter logic [9:0] START_Y  = 10'd400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       jump,
  input  logic [9:0] plataform_start,
  input  logic [9:0] plataform_end,
  output logic [9:0] player_bottom,
  output logic [9:0] player_top,
  output logic [1:0] state,
  output logic       landed,
  output logic       dead
);

  pstate_t    cur, nxt;
  logic [5:0] vel, vel_n;
  logic [9:0] pb_n;
  logic       landed_n;
  logic       jump_q;
  logic       jump_rise;
  logic       tick;
  logic       tick_clear;

  motion_tick #(
    .DIV (TICK_DIV),
    .W   (TICK_W)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .tick  (tick)
  );

  assign jump_rise  = jump & ~jump_q;
  assign state      = cur;
  assign dead       = (cur == DEAD);
  assign player_top = player_bottom - PLAYER_H;

  // Arc arithmetic is done one bit wider so nothing wraps near row 0 or 1023.
  logic [6:0]  fall_sum;
  logic [5:0]  fall_v;
  logic [10:0] fall_next;
  logic [5:0]  rise_v;
  logic        ceiling_hit;
  logic        plat_ok;
  logic        land_hit;

  assign fall_sum    = {1'b0, vel} + {1'b0, GRAVITY};
  assign fall_v      = (fall_sum > {1'b0, MAX_FALL}) ? MAX_FALL : fall_sum[5:0];
  assign fall_next   = {1'b0, player_bottom} + {5'd0, fall_v};
  assign rise_v      = (vel > GRAVITY) ? (vel - GRAVITY) : 6'd0;
  assign ceiling_hit = ({1'b0, player_bottom} < ({5'd0, vel} + {1'b0, PLAYER_H}));
  assign plat_ok     = (plataform_end >= plataform_start);
  assign land_hit    = plat_ok && (player_bottom <= plataform_start) &&
                       (fall_next >= {1'b0, plataform_start});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur           <= STAND;
      player_bottom <= START_Y;
      vel           <= 6'd0;
      landed        <= 1'b0;
      jump_q        <= 1'b0;
    end else begin
      cur           <= nxt;
      player_bottom <= pb_n;
      vel           <= vel_n;
      landed        <= landed_n;
      jump_q        <= jump;
    end
  end

  always_comb begin
    nxt        = cur;
    pb_n       = player_bottom;
    vel_n      = vel;
    landed_n   = 1'b0;
    tick_clear = 1'b0;
    unique case (cur)
      STAND: begin
        pb_n = plataform_start;
        if (plataform_start > SCREEN_BOTTOM) begin
          pb_n = SCREEN_BOTTOM;
          nxt  = DEAD;
        end else if (jump_rise) begin
          vel_n      = JUMP_V;
          tick_clear = 1'b1;
          nxt        = RISE;
        end
      end
      RISE: begin
        if (tick) begin
          if (ceiling_hit) begin
            pb_n  = PLAYER_H;
            vel_n = 6'd0;
            nxt   = FALL;
          end else begin
            pb_n  = player_bottom - {4'd0, vel};
            vel_n = rise_v;
            if (rise_v == 6'd0)
              nxt = FALL;
          end
        end
      end
      FALL: begin
        if (tick) begin
          // Landing is checked first so a platform near the bottom still saves.
          if (land_hit) begin
            pb_n     = plataform_start;
            vel_n    = 6'd0;
            landed_n = 1'b1;
            nxt      = STAND;
          end else if (fall_next >= {1'b0, SCREEN_BOTTOM}) begin
            pb_n = SCREEN_BOTTOM;
            nxt  = DEAD;
          end else begin
            pb_n  = fall_next[9:0];
            vel_n = fall_v;
          end
        end
      end
      DEAD: begin
        nxt = DEAD;
      end
      default: nxt = STAND;
    endcase
  end

endmodule
